// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory byte-bank write path.
package dmem_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 8;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StBeat,
        StSplit
    } state_e;

    // Byte-enable pattern of a store before rotation; illegal sizes write nothing.
    function automatic logic [NUM_LANES-1:0] size_mask(input logic [1:0] size);
        logic [NUM_LANES-1:0] m;
        unique case (size)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Widen a per-lane enable into a per-bit data mask.
    function automatic logic [NUM_LANES*LANE_W-1:0] lane_bits(input logic [NUM_LANES-1:0] m);
        logic [NUM_LANES*LANE_W-1:0] b;
        for (int j = 0; j < NUM_LANES; j++) begin
            b[j*LANE_W +: LANE_W] = {LANE_W{m[j]}};
        end
        return b;
    endfunction

endpackage

// File: rtl/dmem_lane_rotate.sv
// Rotates right-aligned store data onto byte lanes and splits the byte enables
// into the part that fits the addressed word and the part spilling into the next.
module dmem_lane_rotate
    import dmem_pkg::*;
(
    input  logic [31:0]          data_i,
    input  logic [1:0]           size_i,
    input  logic [1:0]           offset_i,
    output logic [31:0]          lane_data_o,
    output logic [NUM_LANES-1:0] mask1_o,
    output logic [NUM_LANES-1:0] mask2_o,
    output logic                 split_o,
    output logic                 illegal_o
);

    logic [63:0]              dbl;
    logic [2*NUM_LANES-1:0]   mask8;

    always_comb begin
        // Left-rotate by 8*offset: lane j receives data byte (j - offset) mod 4.
        dbl         = {data_i, data_i} << {offset_i, 3'b000};
        lane_data_o = dbl[63:32];

        mask8       = {4'b0000, size_mask(size_i)} << offset_i;
        mask1_o     = mask8[NUM_LANES-1:0];
        mask2_o     = mask8[2*NUM_LANES-1:NUM_LANES];
        split_o     = |mask2_o;
        illegal_o   = (size_i == SZ_ILLEGAL);
    end

endmodule

// File: rtl/dmem_store_splitter.sv
// Store path into four byte-wide data banks; word-crossing stores are issued
// as two consecutive bank writes, with all bank-side outputs registered.
module dmem_store_splitter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [3:0]        bank_we,
    output logic [ADDR_W-3:0] bank_addr,
    output logic [7:0]        bank_din0,
    output logic [7:0]        bank_din1,
    output logic [7:0]        bank_din2,
    output logic [7:0]        bank_din3,
    output logic              done,
    output logic              err
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    state_e               state_q, state_d;
    logic                 pend_q, pend_d;
    logic [3:0]           we_q, we_d;
    logic [IDX_W-1:0]     addr_q, addr_d;
    logic [31:0]          din_q, din_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [3:0]           rem_we_q, rem_we_d;
    logic [IDX_W-1:0]     rem_addr_q, rem_addr_d;
    logic [31:0]          rem_din_q, rem_din_d;

    logic [31:0]          lane_data;
    logic [3:0]           mask1, mask2;
    logic                 split, illegal;
    logic                 accept;
    logic                 second_beat;
    logic [IDX_W-1:0]     word_idx;

    dmem_lane_rotate u_rotate (
        .data_i      (req_data),
        .size_i      (req_size),
        .offset_i    (req_addr[1:0]),
        .lane_data_o (lane_data),
        .mask1_o     (mask1),
        .mask2_o     (mask2),
        .split_o     (split),
        .illegal_o   (illegal)
    );

    assign word_idx    = req_addr[ADDR_W-1:2];
    assign second_beat = (state_q == StBeat) && pend_q;
    assign req_ready   = rst_n && !second_beat;
    assign accept      = req_valid && req_ready;

    always_comb begin
        state_d    = StIdle;
        pend_d     = 1'b0;
        we_d       = 4'b0000;
        addr_d     = '0;
        din_d      = 32'h0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rem_we_d   = rem_we_q;
        rem_addr_d = rem_addr_q;
        rem_din_d  = rem_din_q;

        if (second_beat) begin
            state_d = StSplit;
            we_d    = rem_we_q;
            addr_d  = rem_addr_q;
            din_d   = rem_din_q;
            done_d  = 1'b1;
        end else if (accept) begin
            state_d    = StBeat;
            pend_d     = split;
            we_d       = mask1;
            addr_d     = word_idx;
            din_d      = lane_data & lane_bits(mask1);
            done_d     = !split;
            err_d      = illegal;
            // Next word index wraps modulo the index width.
            rem_we_d   = mask2;
            rem_addr_d = word_idx + IDX_W'(1);
            rem_din_d  = lane_data & lane_bits(mask2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pend_q     <= 1'b0;
            we_q       <= 4'b0000;
            addr_q     <= '0;
            din_q      <= 32'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rem_we_q   <= 4'b0000;
            rem_addr_q <= '0;
            rem_din_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rem_we_q   <= rem_we_d;
            rem_addr_q <= rem_addr_d;
            rem_din_q  <= rem_din_d;
        end
    end

    assign bank_we   = we_q;
    assign bank_addr = addr_q;
    assign bank_din0 = din_q[7:0];
    assign bank_din1 = din_q[15:8];
    assign bank_din2 = din_q[23:16];
    assign bank_din3 = din_q[31:24];
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dmem_store_splitter.sv
// Bench for dmem_store_splitter: table vectors, random stores against a byte-level
// model, and a reset landing between the two beats of a split store.
module tb_dmem_store_splitter;

    typedef struct packed {
        logic [3:0]  we;
        logic [29:0] addr;
        logic [31:0] din;
        logic        done;
        logic        err;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        int          nb;
        beat_t       b1;
        beat_t       b2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic [3:0]  bank_we;
    logic [29:0] bank_addr;
    logic [7:0]  bank_din0, bank_din1, bank_din2, bank_din3;
    logic        done, err;

    int    vectors = 0;
    int    miscompares = 0;
    beat_t sb[$];
    vec_t  tbl[11];

    dmem_store_splitter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .bank_we   (bank_we),
        .bank_addr (bank_addr),
        .bank_din0 (bank_din0),
        .bank_din1 (bank_din1),
        .bank_din2 (bank_din2),
        .bank_din3 (bank_din3),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(input logic [3:0] we, input logic [29:0] a,
                                 input logic [31:0] d, input logic dn, input logic er);
        beat_t b;
        b.we = we; b.addr = a; b.din = d; b.done = dn; b.err = er;
        return b;
    endfunction

    // Independent byte-by-byte model of the splitting rule.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         output beat_t b1, output beat_t b2, output int nb);
        int n, o, lane;
        b1 = '0; b2 = '0;
        b1.addr = a[31:2];
        b2.addr = a[31:2] + 30'd1;
        o  = int'(a[1:0]);
        n  = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : (s == 2'b10) ? 4 : 0;
        nb = 1;
        if (s == 2'b11) b1.err = 1'b1;
        for (int k = 0; k < n; k++) begin
            lane = (o + k) % 4;
            if (o + k < 4) begin
                b1.we[lane] = 1'b1;
                b1.din[8*lane +: 8] = d[8*k +: 8];
            end else begin
                b2.we[lane] = 1'b1;
                b2.din[8*lane +: 8] = d[8*k +: 8];
                nb = 2;
            end
        end
        if (nb == 2) b2.done = 1'b1;
        else         b1.done = 1'b1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input beat_t b1, input beat_t b2, input int nb, output int stalls);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        stalls = 0;
        while (!req_ready && stalls < 20) begin
            @(negedge clk);
            stalls++;
        end
        if (!req_ready) begin
            $display("FAIL accept_timeout addr=%h req_ready stuck at 0, required 1", a);
            miscompares++;
            req_valid = 1'b0;
        end else begin
            sb.push_back(b1);
            if (nb == 2) sb.push_back(b2);
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic check_ready(input string name, input logic exp);
        vectors++;
        if (req_ready !== exp) begin
            $display("FAIL %s req_ready=%b required %b", name, req_ready, exp);
            miscompares++;
        end
    endtask

    task automatic check_zero(input string name);
        beat_t got;
        got = mk(bank_we, bank_addr, {bank_din3, bank_din2, bank_din1, bank_din0}, done, err);
        vectors++;
        if (got !== beat_t'(0) || req_ready !== 1'b0) begin
            $display("FAIL %s outputs=%h ready=%b required all zero", name, got, req_ready);
            miscompares++;
        end
    endtask

    // Scoreboard: every beat or pulse observed must match the oldest expected beat.
    always @(negedge clk) begin
        beat_t got, exp;
        if (rst_n && (bank_we != 4'b0000 || done || err)) begin
            got = mk(bank_we, bank_addr, {bank_din3, bank_din2, bank_din1, bank_din0}, done, err);
            vectors++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_beat got we=%b addr=%h din=%h done=%b err=%b, none required",
                         got.we, got.addr, got.din, got.done, got.err);
                miscompares++;
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    $display("FAIL beat got we=%b addr=%h din=%h done=%b err=%b required we=%b addr=%h din=%h done=%b err=%b",
                             got.we, got.addr, got.din, got.done, got.err,
                             exp.we, exp.addr, exp.din, exp.done, exp.err);
                    miscompares++;
                end
            end
        end
    end

    initial begin
        int    stalls, prev_nb, gap, nb;
        beat_t b1, b2;
        logic [31:0] a, d;
        logic [1:0]  s;

        tbl[0]  = '{32'h0000_0010, 32'hDDCC_BBAA, 2'b10, 1,
                    mk(4'b1111, 30'h4, 32'hDDCC_BBAA, 1'b1, 1'b0), '0};
        tbl[1]  = '{32'h0000_0007, 32'h0000_005A, 2'b00, 1,
                    mk(4'b1000, 30'h1, 32'h5A00_0000, 1'b1, 1'b0), '0};
        tbl[2]  = '{32'h0000_0013, 32'h0000_BEEF, 2'b01, 2,
                    mk(4'b1000, 30'h4, 32'hEF00_0000, 1'b0, 1'b0),
                    mk(4'b0001, 30'h5, 32'h0000_00BE, 1'b1, 1'b0)};
        tbl[3]  = '{32'hFFFF_FFFE, 32'h4433_2211, 2'b10, 2,
                    mk(4'b1100, 30'h3FFF_FFFF, 32'h2211_0000, 1'b0, 1'b0),
                    mk(4'b0011, 30'h0, 32'h0000_4433, 1'b1, 1'b0)};
        tbl[4]  = '{32'h0000_0000, 32'h1234_5678, 2'b11, 1,
                    mk(4'b0000, 30'h0, 32'h0, 1'b1, 1'b1), '0};
        tbl[5]  = '{32'h0000_0000, 32'h1111_1111, 2'b10, 1,
                    mk(4'b1111, 30'h0, 32'h1111_1111, 1'b1, 1'b0), '0};
        tbl[6]  = '{32'h0000_0004, 32'h2222_2222, 2'b10, 1,
                    mk(4'b1111, 30'h1, 32'h2222_2222, 1'b1, 1'b0), '0};
        tbl[7]  = '{32'h0000_0002, 32'h0000_1234, 2'b01, 1,
                    mk(4'b1100, 30'h0, 32'h1234_0000, 1'b1, 1'b0), '0};
        tbl[8]  = '{32'h0000_0001, 32'hFFFF_FFAB, 2'b00, 1,
                    mk(4'b0010, 30'h0, 32'h0000_AB00, 1'b1, 1'b0), '0};
        tbl[9]  = '{32'h0000_0001, 32'h0000_CAFE, 2'b01, 1,
                    mk(4'b0110, 30'h0, 32'h00CA_FE00, 1'b1, 1'b0), '0};
        tbl[10] = '{32'h0000_0005, 32'h8765_4321, 2'b10, 2,
                    mk(4'b1110, 30'h1, 32'h6543_2100, 1'b0, 1'b0),
                    mk(4'b0001, 30'h2, 32'h0000_0087, 1'b1, 1'b0)};

        #3 check_zero("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table vectors back to back; only a preceding split may cost a cycle.
        prev_nb = 1;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].addr, tbl[i].data, tbl[i].size, tbl[i].b1, tbl[i].b2, tbl[i].nb, stalls);
            vectors++;
            if (stalls != ((prev_nb == 2) ? 1 : 0)) begin
                $display("FAIL stall_vec%0d stalls=%0d required %0d", i, stalls, (prev_nb == 2) ? 1 : 0);
                miscompares++;
            end
            prev_nb = tbl[i].nb;
        end

        // Random stores with random gaps.
        for (int i = 0; i < 300; i++) begin
            a   = $urandom;
            if ($urandom_range(0, 9) == 0) a[31:2] = 30'h3FFF_FFFF;
            d   = $urandom;
            s   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
            repeat (gap) @(negedge clk);
            model(a, d, s, b1, b2, nb);
            drive(a, d, s, b1, b2, nb, stalls);
            vectors++;
            if (stalls != ((prev_nb == 2 && gap == 0) ? 1 : 0)) begin
                $display("FAIL stall_rand%0d stalls=%0d gap=%0d prev_nb=%0d", i, stalls, gap, prev_nb);
                miscompares++;
            end
            prev_nb = nb;
        end

        // Split store with reset landing on its first beat: second beat must vanish.
        repeat (2) @(negedge clk);
        model(32'h0000_0013, 32'h0000_BEEF, 2'b01, b1, b2, nb);
        drive(32'h0000_0013, 32'h0000_BEEF, 2'b01, b1, b2, 1, stalls);
        @(negedge clk);
        check_ready("ready_low_beat1", 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset_mid_split");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_ready("ready_after_release", 1'b1);
        repeat (4) @(negedge clk);

        model(32'h0000_0020, 32'hCAFE_F00D, 2'b10, b1, b2, nb);
        drive(32'h0000_0020, 32'hCAFE_F00D, 2'b10, b1, b2, nb, stalls);
        repeat (4) @(negedge clk);

        vectors++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain %0d beats outstanding, required 0", sb.size());
            miscompares++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
